// File: rtl/banner_pkg.sv
// Shared encodings for the banner scroller: session modes and FSM states.
package banner_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC = 2'd0;
    localparam mode_t MODE_LOOP   = 2'd1;
    localparam mode_t MODE_ONCE   = 2'd2;
    localparam mode_t MODE_BLINK  = 2'd3;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_FETCH      = 2'd2;
    localparam logic [1:0] ST_STREAM     = 2'd3;

endpackage

// File: rtl/banner_rom.sv
// Banner bitmap ROM with registered address and 1-cycle read latency; output holds while en is low.
// The image is compiled in (row k holds k); an empty INIT_FILE selects a blank banner.
module banner_rom #(
    parameter int    ROW_W     = 57,
    parameter int    NUM_ROWS  = 129,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = "banner.mem"
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  data
);

    localparam bit BLANK_IMAGE = (INIT_FILE == "");

    logic [ROW_W-1:0]  image [NUM_ROWS];
    logic [ADDR_W-1:0] addr_q;

    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_image
        assign image[k] = BLANK_IMAGE ? '0 : ROW_W'(k);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            addr_q <= addr;
        end
    end

    assign data = ({1'b0, addr_q} < (ADDR_W + 1)'(NUM_ROWS)) ? image[addr_q] : '0;

endmodule

// File: rtl/banner_scroller.sv
// Banner engine: streams WIN_ROWS ROM rows per frame_req with per-frame scroll/blink offset.
// First row 2 cycles after frame_req, one row per 2 cycles; rows hold stable until row_ready.
module banner_scroller
    import banner_pkg::*;
#(
    parameter int    ROW_W        = 57,
    parameter int    NUM_ROWS     = 129,
    parameter int    WIN_ROWS     = 32,
    parameter int    ADDR_W       = 8,
    parameter int    STEP_FRAMES  = 4,
    parameter int    BLINK_FRAMES = 16,
    parameter string INIT_FILE    = "banner.mem"
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        frame_req,
    input  logic                        row_ready,
    output logic                        row_valid,
    output logic [ROW_W-1:0]            row_data,
    output logic [$clog2(WIN_ROWS)-1:0] row_idx,
    output logic                        frame_done,
    output logic                        scroll_done,
    output logic                        busy,
    output logic [ADDR_W-1:0]           offset
);

    localparam int RIDX_W   = $clog2(WIN_ROWS);
    localparam int SUM_W    = ADDR_W + 1;
    localparam int FCNT_MAX = (2 * BLINK_FRAMES > STEP_FRAMES) ? 2 * BLINK_FRAMES : STEP_FRAMES;
    localparam int FCNT_W   = $clog2(FCNT_MAX + 1);

    logic [1:0]        state;
    mode_t             mode_q;
    logic [RIDX_W-1:0] row_cnt;
    logic [FCNT_W-1:0] fcnt;
    logic              blank_q;

    logic [SUM_W-1:0]  sum;
    logic              sum_over;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROW_W-1:0]  rom_data;
    logic              blank_next;
    logic              last_row;
    logic [FCNT_W-1:0] fcnt_inc;
    logic [SUM_W-1:0]  off_inc;
    logic              off_end;

    // Window row address: LOOP folds past-the-end rows back to the top of the banner.
    assign sum      = {1'b0, offset} + SUM_W'(row_cnt);
    assign sum_over = (sum >= SUM_W'(NUM_ROWS));
    assign rom_addr = ((mode_q == MODE_LOOP) && sum_over) ? ADDR_W'(sum - SUM_W'(NUM_ROWS))
                                                          : ADDR_W'(sum);

    assign blank_next = ((mode_q == MODE_ONCE) && sum_over) ||
                        ((mode_q == MODE_BLINK) && (fcnt >= FCNT_W'(BLINK_FRAMES)));

    assign last_row = (row_cnt == RIDX_W'(WIN_ROWS - 1));
    assign fcnt_inc = fcnt + FCNT_W'(1);
    assign off_inc  = {1'b0, offset} + SUM_W'(1);
    assign off_end  = (off_inc == SUM_W'(NUM_ROWS));

    banner_rom #(
        .ROW_W     (ROW_W),
        .NUM_ROWS  (NUM_ROWS),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .en   (state == ST_FETCH),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign row_valid = (state == ST_STREAM);
    assign row_idx   = row_cnt;
    assign row_data  = (row_valid && !blank_q) ? rom_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_STATIC;
            offset      <= '0;
            fcnt        <= '0;
            row_cnt     <= '0;
            blank_q     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            scroll_done <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            scroll_done <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= start;
                        if (start) begin
                            mode_q  <= mode;
                            offset  <= '0;
                            fcnt    <= '0;
                            row_cnt <= '0;
                            state   <= ST_WAIT_FRAME;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (frame_req) begin
                            state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        blank_q <= blank_next;
                        state   <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (row_ready && !last_row) begin
                            row_cnt <= row_cnt + RIDX_W'(1);
                            state   <= ST_FETCH;
                        end else if (row_ready) begin
                            row_cnt    <= '0;
                            frame_done <= 1'b1;
                            state      <= ST_WAIT_FRAME;
                            if ((mode_q == MODE_LOOP) || (mode_q == MODE_ONCE)) begin
                                if (fcnt_inc == FCNT_W'(STEP_FRAMES)) begin
                                    fcnt <= '0;
                                    if (mode_q == MODE_LOOP) begin
                                        offset <= off_end ? '0 : off_inc[ADDR_W-1:0];
                                    end else begin
                                        // Final ONCE step: busy stays up through this pulse cycle.
                                        offset <= off_inc[ADDR_W-1:0];
                                        if (off_end) begin
                                            scroll_done <= 1'b1;
                                            state       <= ST_IDLE;
                                        end
                                    end
                                end else begin
                                    fcnt <= fcnt_inc;
                                end
                            end else if (mode_q == MODE_BLINK) begin
                                fcnt <= (fcnt_inc == FCNT_W'(2 * BLINK_FRAMES)) ? '0 : fcnt_inc;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller; ROM row k holds k.
`timescale 1ns/1ps
module tb_banner_scroller;

    localparam int ROW_W    = 57;
    localparam int NUM_ROWS = 129;
    localparam int WIN_ROWS = 32;
    localparam int ADDR_W   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              frame_req = 1'b0;
    logic              row_ready = 1'b0;
    logic              row_valid;
    logic [ROW_W-1:0]  row_data;
    logic [4:0]        row_idx;
    logic              frame_done;
    logic              scroll_done;
    logic              busy;
    logic [ADDR_W-1:0] offset;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ROW_W-1:0] cap_data [WIN_ROWS];
    int               cap_idx  [WIN_ROWS];
    int               cap_n, cap_done, cap_scroll, cap_first_c;
    bit               cap_gap_bad, cap_tmo;
    logic             cap_busy_at_done;

    banner_scroller dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .start       (start),
        .stop        (stop),
        .frame_req   (frame_req),
        .row_ready   (row_ready),
        .row_valid   (row_valid),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .frame_done  (frame_done),
        .scroll_done (scroll_done),
        .busy        (busy),
        .offset      (offset)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_session(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Requests one frame with row_ready held high and records what the DUT streams.
    task automatic run_frame();
        int  last_c;
        bit  fin;
        cap_n = 0; cap_done = 0; cap_scroll = 0; cap_first_c = -1;
        cap_gap_bad = 1'b0; cap_tmo = 1'b0; cap_busy_at_done = 1'b0;
        last_c = -2; fin = 1'b0;
        row_ready = 1'b1;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (row_valid) begin
                if (cap_n < WIN_ROWS) begin
                    cap_data[cap_n] = row_data;
                    cap_idx[cap_n]  = int'(row_idx);
                end
                if (cap_n == 0) cap_first_c = c;
                else if (c - last_c != 2) cap_gap_bad = 1'b1;
                last_c = c;
                cap_n++;
            end
            if (scroll_done) cap_scroll++;
            if (frame_done) begin
                cap_done++;
                cap_busy_at_done = busy;
                fin = 1'b1;
            end
            @(negedge clk);
        end
        if (!fin) cap_tmo = 1'b1;
    endtask

    // Requests a frame and stops at the negedge where row k is presented (before its handshake).
    task automatic wait_row(input int k, output bit found);
        found = 1'b0;
        row_ready = 1'b1;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (row_valid && int'(row_idx) == k) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit found;
        do_reset();
        n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid: got %b want 0", row_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (offset !== '0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", offset); end
        n_checks++; if (row_data !== '0) begin n_fail++; $display("FAIL reset_row_data: got %0h want 0", row_data); end
        n_checks++; if (frame_done !== 1'b0 || scroll_done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: frame_done=%b scroll_done=%b want 0 0", frame_done, scroll_done); end
        start_session(2'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
        wait_row(5, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL reset_reach_row5: row 5 not seen within bound"); end
        n_checks++; if (row_data !== ROW_W'(5)) begin n_fail++; $display("FAIL reset_row5_data: got %0d want 5", row_data); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (row_valid !== 1'b0 || busy !== 1'b0 || offset !== '0 || row_data !== '0) begin
            n_fail++; $display("FAIL midframe_reset: valid=%b busy=%b offset=%0d data=%0h want all 0", row_valid, busy, offset, row_data);
        end
        n_checks++; if (frame_done !== 1'b0 || row_idx !== '0) begin n_fail++; $display("FAIL midframe_reset_idx: frame_done=%b row_idx=%0d want 0 0", frame_done, row_idx); end
        rst = 1'b0;
        start_session(2'd1);
        n_checks++; if (busy !== 1'b1 || offset !== '0) begin n_fail++; $display("FAIL restart_after_reset: busy=%b offset=%0d want 1 0", busy, offset); end
        run_frame();
        n_checks++; if (cap_n !== WIN_ROWS || cap_done !== 1 || cap_data[5] !== ROW_W'(5)) begin
            n_fail++; $display("FAIL restart_frame: rows=%0d done=%0d row5=%0d want 32 1 5", cap_n, cap_done, cap_data[5]);
        end
    endtask

    task automatic test_static();
        do_reset();
        start_session(2'd0);
        for (int f = 0; f < 10; f++) begin
            run_frame();
            n_checks++; if (cap_tmo || cap_n !== WIN_ROWS || cap_done !== 1) begin n_fail++; $display("FAIL static_frame%0d: rows=%0d done=%0d tmo=%b want 32 1 0", f, cap_n, cap_done, cap_tmo); end
            n_checks++; if (cap_first_c !== 1) begin n_fail++; $display("FAIL static_latency%0d: first row at %0d want 1", f, cap_first_c); end
            n_checks++; if (cap_gap_bad) begin n_fail++; $display("FAIL static_spacing%0d: rows not 2 cycles apart", f); end
            for (int i = 0; i < WIN_ROWS; i++) begin
                n_checks++; if (cap_data[i] !== ROW_W'(i) || cap_idx[i] !== i) begin
                    n_fail++; $display("FAIL static_row f%0d r%0d: data=%0d idx=%0d want %0d %0d", f, i, cap_data[i], cap_idx[i], i, i);
                end
            end
            n_checks++; if (offset !== '0) begin n_fail++; $display("FAIL static_offset%0d: got %0d want 0", f, offset); end
        end
    endtask

    task automatic test_loop();
        do_reset();
        start_session(2'd1);
        for (int f = 0; f < 400; f++) begin
            run_frame();
            n_checks++; if (cap_tmo || cap_n !== WIN_ROWS || cap_done !== 1) begin n_fail++; $display("FAIL loop_frame%0d: rows=%0d done=%0d", f, cap_n, cap_done); end
        end
        n_checks++; if (offset !== 8'd100) begin n_fail++; $display("FAIL loop_offset400: got %0d want 100", offset); end
        run_frame();
        n_checks++; if (cap_data[0] !== ROW_W'(100)) begin n_fail++; $display("FAIL loop_row0: got %0d want 100", cap_data[0]); end
        n_checks++; if (cap_data[28] !== ROW_W'(128)) begin n_fail++; $display("FAIL loop_row28: got %0d want 128", cap_data[28]); end
        n_checks++; if (cap_data[29] !== ROW_W'(0)) begin n_fail++; $display("FAIL loop_row29_wrap: got %0d want 0", cap_data[29]); end
        n_checks++; if (cap_data[31] !== ROW_W'(2)) begin n_fail++; $display("FAIL loop_row31: got %0d want 2", cap_data[31]); end
        for (int f = 401; f < 512; f++) begin
            run_frame();
            n_checks++; if (cap_tmo || cap_n !== WIN_ROWS || cap_done !== 1) begin n_fail++; $display("FAIL loop_frame%0d: rows=%0d done=%0d", f, cap_n, cap_done); end
        end
        n_checks++; if (offset !== 8'd128) begin n_fail++; $display("FAIL loop_offset512: got %0d want 128", offset); end
        for (int f = 512; f < 516; f++) run_frame();
        n_checks++; if (offset !== 8'd0) begin n_fail++; $display("FAIL loop_offset516: got %0d want 0", offset); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy: got %b want 1", busy); end
    endtask

    task automatic test_once();
        int total_scroll;
        int seen;
        total_scroll = 0;
        do_reset();
        start_session(2'd2);
        for (int f = 0; f < 440; f++) begin
            run_frame();
            total_scroll += cap_scroll;
            n_checks++; if (cap_tmo || cap_n !== WIN_ROWS || cap_done !== 1) begin n_fail++; $display("FAIL once_frame%0d: rows=%0d done=%0d", f, cap_n, cap_done); end
        end
        n_checks++; if (offset !== 8'd110) begin n_fail++; $display("FAIL once_offset440: got %0d want 110", offset); end
        run_frame();
        total_scroll += cap_scroll;
        n_checks++; if (cap_n !== WIN_ROWS) begin n_fail++; $display("FAIL once_blank_rows_streamed: rows=%0d want 32", cap_n); end
        for (int i = 0; i < WIN_ROWS; i++) begin
            n_checks++; if (cap_data[i] !== ((i < 19) ? ROW_W'(110 + i) : ROW_W'(0))) begin
                n_fail++; $display("FAIL once_row r%0d: got %0d want %0d", i, cap_data[i], (i < 19) ? 110 + i : 0);
            end
        end
        for (int f = 441; f < 516; f++) begin
            run_frame();
            total_scroll += cap_scroll;
            n_checks++; if (cap_tmo || cap_n !== WIN_ROWS || cap_done !== 1) begin n_fail++; $display("FAIL once_frame%0d: rows=%0d done=%0d", f, cap_n, cap_done); end
        end
        n_checks++; if (cap_scroll !== 1) begin n_fail++; $display("FAIL once_scroll_final: pulses in last frame=%0d want 1", cap_scroll); end
        n_checks++; if (total_scroll !== 1) begin n_fail++; $display("FAIL once_scroll_count: total=%0d want 1", total_scroll); end
        n_checks++; if (cap_busy_at_done !== 1'b1) begin n_fail++; $display("FAIL once_busy_at_done: got %b want 1", cap_busy_at_done); end
        n_checks++; if (busy !== 1'b0 || scroll_done !== 1'b0) begin n_fail++; $display("FAIL once_busy_after: busy=%b scroll_done=%b want 0 0", busy, scroll_done); end
        seen = 0;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (row_valid || frame_done) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL once_no_rows_after: active cycles=%0d want 0", seen); end
    endtask

    task automatic test_backpressure();
        int  n;
        int  dups;
        bit  stalled;
        bit  fin;
        logic [ROW_W-1:0] got_d [WIN_ROWS];
        int  got_i [WIN_ROWS];
        n = 0; dups = 0; stalled = 1'b0; fin = 1'b0;
        do_reset();
        start_session(2'd0);
        row_ready = 1'b1;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (row_valid && row_idx == 5'd3 && !stalled) begin
                row_ready = 1'b0;
                stalled = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_checks++; if (row_valid !== 1'b1 || row_idx !== 5'd3 || row_data !== ROW_W'(3)) begin
                        n_fail++; $display("FAIL bp_hold c%0d: valid=%b idx=%0d data=%0d want 1 3 3", k, row_valid, row_idx, row_data);
                    end
                end
                row_ready = 1'b1;
            end
            if (row_valid && row_ready) begin
                if (n < WIN_ROWS) begin
                    got_d[n] = row_data;
                    got_i[n] = int'(row_idx);
                end
                n++;
            end
            if (frame_done) fin = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (!stalled || !fin || n !== WIN_ROWS) begin n_fail++; $display("FAIL bp_frame: stalled=%b done=%b rows=%0d want 1 1 32", stalled, fin, n); end
        for (int i = 0; i < WIN_ROWS && i < n; i++) begin
            if (got_d[i] !== ROW_W'(i) || got_i[i] !== i) dups++;
        end
        n_checks++; if (dups !== 0) begin n_fail++; $display("FAIL bp_sequence: %0d rows out of order want 0", dups); end
    endtask

    task automatic test_blink();
        logic [ROW_W-1:0] exp;
        do_reset();
        start_session(2'd3);
        for (int f = 0; f < 33; f++) begin
            run_frame();
            n_checks++; if (cap_tmo || cap_n !== WIN_ROWS || cap_done !== 1 || cap_gap_bad) begin
                n_fail++; $display("FAIL blink_frame%0d: rows=%0d done=%0d gap_bad=%b", f, cap_n, cap_done, cap_gap_bad);
            end
            for (int i = 0; i < WIN_ROWS; i++) begin
                exp = ((f % 32) < 16) ? ROW_W'(i) : '0;
                n_checks++; if (cap_data[i] !== exp || cap_idx[i] !== i) begin
                    n_fail++; $display("FAIL blink_row f%0d r%0d: data=%0d idx=%0d want %0d %0d", f, i, cap_data[i], cap_idx[i], exp, i);
                end
            end
            n_checks++; if (offset !== '0) begin n_fail++; $display("FAIL blink_offset%0d: got %0d want 0", f, offset); end
        end
    endtask

    task automatic test_stop();
        bit found;
        int seen;
        wait_row(7, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL stop_reach_row7: row 7 not seen within bound"); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++; if (row_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL stop_next: valid=%b busy=%b frame_done=%b want 0 0 0", row_valid, busy, frame_done);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (frame_done || row_valid || busy) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL stop_quiet: active cycles=%0d want 0", seen); end
        start_session(2'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_restart_busy: got %b want 1", busy); end
        run_frame();
        n_checks++; if (cap_n !== WIN_ROWS || cap_done !== 1 || cap_data[0] !== '0 || cap_data[7] !== ROW_W'(7)) begin
            n_fail++; $display("FAIL stop_restart_frame: rows=%0d done=%0d r0=%0d r7=%0d want 32 1 0 7", cap_n, cap_done, cap_data[0], cap_data[7]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_static();
        test_backpressure();
        test_loop();
        test_once();
        test_blink();
        test_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/banner_scroller.md
# banner_scroller

Parametrised banner engine for the LED-matrix display path. It holds a bitmap ROM of `NUM_ROWS` rows, each `ROW_W` bits wide, and streams a window of `WIN_ROWS` rows per display frame to the matrix driver over a valid/ready row interface. Each frame is one display refresh requested by the driver through `frame_req`. Per-frame window offset advances according to a selectable mode: static, looping scroll, one-shot scroll, or blink. It replaces fixed single-banner ROMs read directly by the driver.

## Interface
- `ROW_W`, 57: bits per banner row.
- `NUM_ROWS`, 129: rows stored in the ROM. Constraint: `NUM_ROWS` ≤ 2^`ADDR_W`.
- `WIN_ROWS`, 32: rows streamed per frame. Constraint: `WIN_ROWS` ≤ `NUM_ROWS`.
- `ADDR_W`, 8: ROM address width.
- `STEP_FRAMES`, 4: frames per one-row scroll step.
- `BLINK_FRAMES`, 16: frames per blink phase.
- `INIT_FILE`, "banner.mem": ROM contents.
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `mode`, in, 2: 0 STATIC, 1 LOOP, 2 ONCE, 3 BLINK. Sampled only on an accepted `start`.
- `start`, in, 1: pulse that begins a banner session.
- `stop`, in, 1: pulse that aborts the session.
- `frame_req`, in, 1: pulse from the driver requesting one frame.
- `row_ready`, in, 1: driver accepts the current row.
- `row_valid`, out, 1: `row_data` and `row_idx` are valid.
- `row_data`, out, `ROW_W`: row bitmap.
- `row_idx`, out, clog2(`WIN_ROWS`): row position within the window.
- `frame_done`, out, 1: one-cycle pulse after the last row handshake of a frame.
- `scroll_done`, out, 1: one-cycle pulse when a ONCE session completes.
- `busy`, out, 1: a session is active.
- `offset`, out, `ADDR_W`: current window start row.

## Operation
- FSM states: IDLE, WAIT_FRAME, FETCH, STREAM.
- IDLE: `start` latches `mode`, clears `offset`, the frame counter and the row counter, then moves to WAIT_FRAME. `start` in any other state is ignored.
- WAIT_FRAME: `frame_req` moves the FSM to FETCH. `frame_req` in FETCH or STREAM is ignored and is not queued.
- FETCH: presents the row address to the ROM, which has 1-cycle latency. Next state is STREAM.
- STREAM: `row_valid`=1. `row_data` and `row_idx` are held stable until `row_ready`.
  - On a handshake with `row_idx` < `WIN_ROWS`-1: increment the row counter and return to FETCH.
  - On the last handshake: return to WAIT_FRAME, clear the row counter, and end the frame.
- Address arithmetic: `sum = offset + row_idx`, computed in `ADDR_W`+1 bits.
  - LOOP: if `sum` ≥ `NUM_ROWS`, address = `sum` − `NUM_ROWS`. Wrap-around is exact.
  - ONCE: if `sum` ≥ `NUM_ROWS`, the row is blanked (`row_data`=0) and is still streamed with `row_valid`=1.
  - STATIC and BLINK: `offset` stays 0.
- End of frame: increment the frame counter.
  - LOOP and ONCE: when the counter reaches `STEP_FRAMES`, clear it and increment `offset`.
  - LOOP: `offset` wraps from `NUM_ROWS`−1 to 0.
  - ONCE: when `offset` reaches `NUM_ROWS`, pulse `scroll_done`, drop `busy`, and go to IDLE.
- BLINK: the frame counter counts to 2×`BLINK_FRAMES`. Frames in the second half stream all-zero rows, with the handshake unchanged.
- `stop`: in any non-IDLE state, go to IDLE the next cycle. `row_valid`, `busy` and `frame_done` clear. No partial-frame `frame_done` is issued.
- Priority, highest first: `rst`, then `stop`, then `start`/`frame_req`.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- `start` at cycle t gives `busy`=1 at t+1.
- `frame_req` at cycle t in WAIT_FRAME gives FETCH at t+1 and the first `row_valid` at t+2.
- Row throughput: a handshake at cycle h gives the next `row_valid` at h+2. The cycle h+1 in FETCH has `row_valid`=0.
- `frame_done` goes high at h+1 after the final handshake at h. The updated `offset` is visible in that same cycle.
- `scroll_done` coincides with the `frame_done` of the final ONCE frame. `busy`=0 from the following cycle.
- `rst` mid-frame: all outputs are 0 on the next cycle. No pending state survives.

## Structure
- Shared package `banner_pkg` holds:
  - mode encodings MODE_STATIC, MODE_LOOP, MODE_ONCE, MODE_BLINK;
  - FSM state encodings.
- Sub-module `banner_rom`: parametrised (`ROW_W`, `NUM_ROWS`, `ADDR_W`, `INIT_FILE`), block-RAM style, registered address, 1-cycle read latency. Out-of-range addresses return zero.
- The top level contains the FSM, the row/frame counters, offset/wrap arithmetic, and blank gating.

## Test plan
Bench ROM: row k holds the value k.
- **Reset:** assert `rst` during STREAM row 5 → next cycle `row_valid`, `busy`, `offset` and `row_data` are all 0. A subsequent `start` is accepted.
- **STATIC:** `mode`=0, 10 frames, `row_ready`=1 → each frame gives `row_idx` 0..31 with data 0..31, rows 2 cycles apart, one `frame_done` per frame, `offset` stays 0.
- **LOOP wrap:** `mode`=1, run 400 frames → `offset`=100 and frame row 29 carries data 0 (address 129 wraps to 0). After 516 frames `offset` returns to 0.
- **ONCE end:**
  - `mode`=2 → at `offset`=110, rows 19..31 are zero.
  - After 516 frames → `scroll_done` pulses once and `busy`=0.
  - A further `frame_req` produces no rows.
- **Backpressure:** `row_ready`=0 for 5 cycles at row 3 → `row_valid`=1 with `row_idx`=3 and data=3 held stable. No row is skipped or duplicated.
- **BLINK and stop:**
  - `mode`=3 → frames 0–15 carry data, frames 16–31 are all-zero with the handshake intact.
  - `stop` at row 7 → `row_valid`=0 and `busy`=0 next cycle, no `frame_done`, and a new `start` is accepted.
